kmeans_point_loader: RTL and testbench

KMEANS_POINT_LOADER -- requirements
Module: kmeans_point_loader

---
 rtl/kmeans_point_loader.sv | 203 ++++++++++++++++++++
 tb/tb_kmeans_point_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kmeans_point_loader.sv
// K-means point loader: assembles X/Y/Z byte triplets from a byte stream into
// point-memory writes, checks the frame length against N points and launches
// clustering once a complete frame is held.
//
// Handshake: a byte is transferred on a rising clk edge when in_valid and
// in_ready are both 1; in_ready depends only on the current state, and
// in_data/in_last are meaningful only while in_valid is 1.
module kmeans_point_loader #(
    parameter int N = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_last,
    output logic       mem_we,
    output logic [4:0] mem_waddr,
    output logic [7:0] mem_wx,
    output logic [7:0] mem_wy,
    output logic [7:0] mem_wz,
    output logic [1:0] mem_wlabel,
    output logic       start_kmeans,
    output logic       loaded,
    output logic       err_short,
    output logic       err_long,
    output logic [4:0] count,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        DRAIN   = 3'd2,
        DONE    = 3'd3,
        ERR     = 3'd4
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(N - 1);
    localparam logic [4:0] NPTS     = 5'(N);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;           // 0 = X, 1 = Y, 2 = Z
    logic [7:0] x_hold_q, x_hold_d;
    logic [7:0] y_hold_q, y_hold_d;
    logic [4:0] count_q, count_d;
    logic       mem_we_q, mem_we_d;
    logic [4:0] mem_waddr_q, mem_waddr_d;
    logic [7:0] mem_wx_q, mem_wx_d;
    logic [7:0] mem_wy_q, mem_wy_d;
    logic [7:0] mem_wz_q, mem_wz_d;
    logic [1:0] mem_wlabel_q, mem_wlabel_d;
    logic       start_pend_q, start_pend_d;  // final write is on the bus now
    logic       start_q, start_d;
    logic       loaded_q, loaded_d;
    logic       err_short_q, err_short_d;
    logic       err_long_q, err_long_d;

    logic accept;
    logic final_z;

    assign in_ready = (state_q == COLLECT) || (state_q == DRAIN);
    assign accept   = in_valid && in_ready;
    assign final_z  = (sel_q == 2'd2) && (count_q == LAST_IDX);

    // Next-state and registered-output computation for the whole loader.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        x_hold_d     = x_hold_q;
        y_hold_d     = y_hold_q;
        count_d      = count_q;
        mem_we_d     = 1'b0;
        mem_waddr_d  = mem_waddr_q;
        mem_wx_d     = mem_wx_q;
        mem_wy_d     = mem_wy_q;
        mem_wz_d     = mem_wz_q;
        mem_wlabel_d = mem_wlabel_q;
        start_pend_d = 1'b0;
        start_d      = start_pend_q;   // pulse one cycle after the final write
        loaded_d     = loaded_q;
        err_short_d  = err_short_q;
        err_long_d   = err_long_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (load_start) begin
                    state_d     = COLLECT;
                    count_d     = 5'd0;
                    sel_d       = 2'd0;
                    loaded_d    = 1'b0;
                    err_short_d = 1'b0;
                    err_long_d  = 1'b0;
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (in_last && !final_z) begin
                        // Frame ended early: drop the partial point.
                        state_d     = ERR;
                        err_short_d = 1'b1;
                        sel_d       = 2'd0;
                    end else begin
                        case (sel_q)
                            2'd0: begin
                                x_hold_d = in_data;
                                sel_d    = 2'd1;
                            end
                            2'd1: begin
                                y_hold_d = in_data;
                                sel_d    = 2'd2;
                            end
                            default: begin
                                sel_d        = 2'd0;
                                mem_we_d     = 1'b1;
                                mem_waddr_d  = count_q;
                                mem_wx_d     = x_hold_q;
                                mem_wy_d     = y_hold_q;
                                mem_wz_d     = in_data;
                                mem_wlabel_d = 2'b00;
                                if (count_q < NPTS) begin
                                    count_d = count_q + 5'd1;
                                end
                                if (final_z) begin
                                    if (in_last) begin
                                        state_d      = DONE;
                                        loaded_d     = 1'b1;
                                        start_pend_d = 1'b1;
                                    end else begin
                                        state_d    = DRAIN;
                                        err_long_d = 1'b1;
                                    end
                                end
                            end
                        endcase
                    end
                end
            end
            DRAIN: begin
                if (accept && in_last) begin
                    state_d      = DONE;
                    loaded_d     = 1'b1;
                    start_pend_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All loader state, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= 2'd0;
            x_hold_q     <= 8'd0;
            y_hold_q     <= 8'd0;
            count_q      <= 5'd0;
            mem_we_q     <= 1'b0;
            mem_waddr_q  <= 5'd0;
            mem_wx_q     <= 8'd0;
            mem_wy_q     <= 8'd0;
            mem_wz_q     <= 8'd0;
            mem_wlabel_q <= 2'd0;
            start_pend_q <= 1'b0;
            start_q      <= 1'b0;
            loaded_q     <= 1'b0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            x_hold_q     <= x_hold_d;
            y_hold_q     <= y_hold_d;
            count_q      <= count_d;
            mem_we_q     <= mem_we_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_wx_q     <= mem_wx_d;
            mem_wy_q     <= mem_wy_d;
            mem_wz_q     <= mem_wz_d;
            mem_wlabel_q <= mem_wlabel_d;
            start_pend_q <= start_pend_d;
            start_q      <= start_d;
            loaded_q     <= loaded_d;
            err_short_q  <= err_short_d;
            err_long_q   <= err_long_d;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_waddr    = mem_waddr_q;
    assign mem_wx       = mem_wx_q;
    assign mem_wy       = mem_wy_q;
    assign mem_wz       = mem_wz_q;
    assign mem_wlabel   = mem_wlabel_q;
    assign start_kmeans = start_q;
    assign loaded       = loaded_q;
    assign err_short    = err_short_q;
    assign err_long     = err_long_q;
    assign count        = count_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_kmeans_point_loader.sv
// Bench for kmeans_point_loader: directed frames, expected writes queued by the
// driver and popped by an independent monitor on each mem_we.
module tb_kmeans_point_loader;
  localparam int N = 11;

  logic       clk;
  logic       rst;
  logic       load_start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       in_last;
  logic       mem_we;
  logic [4:0] mem_waddr;
  logic [7:0] mem_wx, mem_wy, mem_wz;
  logic [1:0] mem_wlabel;
  logic       start_kmeans;
  logic       loaded;
  logic       err_short, err_long;
  logic [4:0] count;
  logic [2:0] dbg_state;

  kmeans_point_loader #(.N(N)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wx(mem_wx), .mem_wy(mem_wy),
    .mem_wz(mem_wz), .mem_wlabel(mem_wlabel), .start_kmeans(start_kmeans),
    .loaded(loaded), .err_short(err_short), .err_long(err_long),
    .count(count), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [30:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int start_cnt = 0;
  int acc_cnt = 0;
  int first_acc = 0;
  int first_wr = 0;
  int last_wr = 0;
  bit timing = 0;
  logic [7:0] b[40];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // monitor: inputs change just after posedge, so negedge sees stable values
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        if (acc_cnt == 0) first_acc = cyc + 1;
        acc_cnt++;
      end
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {1'b0, mem_waddr, mem_wx, mem_wy, mem_wz, mem_wlabel}, 32'hffffffff);
        end else begin
          check("write", {1'b0, mem_waddr, mem_wx, mem_wy, mem_wz, mem_wlabel}, {1'b0, exp_q.pop_front()});
        end
        wr_cnt++;
        check("count_tracks_writes", 32'(count), 32'(wr_cnt));
        if (wr_cnt == 1) first_wr = cyc;
        if (timing) check("write_cycle", 32'(cyc - first_acc), 32'(2 + 3 * (wr_cnt - 1)));
        last_wr = cyc;
      end
      if (start_kmeans) begin
        start_cnt++;
        if (timing) check("start_cycle", 32'(cyc), 32'(last_wr + 1));
      end
    end
  end

  // driver tasks (all called at posedge+1)
  task automatic pulse_load();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last, input int gap);
    bit ok;
    bit done;
    done = 0;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int t = 0; t < 50 && !done; t++) begin
      ok = in_ready;
      @(posedge clk); #1;
      if (ok) done = 1;
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_bus();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic clear_sb();
    wr_cnt = 0; start_cnt = 0; acc_cnt = 0;
  endtask

  // push expected writes for an n-byte frame, then drive it
  task automatic run_frame(input int n, input bit rnd, input bit mid_load);
    clear_sb();
    pulse_load();
    for (int p = 0; p < N; p++) begin
      if (3 * p + 2 < n - 1 || (p == N - 1 && 3 * p + 2 < n))
        exp_q.push_back({5'(p), b[3*p], b[3*p+1], b[3*p+2], 2'b00});
    end
    for (int k = 0; k < n; k++) begin
      if (mid_load && k == 10) begin
        idle_bus();
        pulse_load();
      end
      send_byte(b[k], k == n - 1, rnd ? int'($urandom_range(0, 2)) : 0);
    end
    idle_bus();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 0);
    check({tag, "_mem_we"}, 32'(mem_we), 0);
    check({tag, "_start"}, 32'(start_kmeans), 0);
    check({tag, "_loaded"}, 32'(loaded), 0);
    check({tag, "_err_short"}, 32'(err_short), 0);
    check({tag, "_err_long"}, 32'(err_long), 0);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_waddr"}, 32'(mem_waddr), 0);
    check({tag, "_wxyz"}, {8'd0, mem_wx, mem_wy, mem_wz}, 0);
    check({tag, "_wlabel"}, 32'(mem_wlabel), 0);
  endtask

  initial begin
    b[0] = 8'd12; b[1] = 8'd50; b[2] = 8'd10;
    for (int k = 3; k < 40; k++) b[k] = 8'(k * 7 + 3);
    rst = 1'b1; load_start = 1'b0; in_data = 8'd0; in_valid = 1'b0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // bytes offered in IDLE are neither consumed nor counted
    in_valid = 1'b1; in_data = 8'h77;
    repeat (4) @(posedge clk);
    #1;
    idle_bus();
    check("idle_ready", 32'(in_ready), 0);
    check("idle_acc", 32'(acc_cnt), 0);
    check("idle_writes", 32'(wr_cnt), 0);

    // clean continuous frame with cycle timing
    timing = 1;
    run_frame(33, 0, 0);
    timing = 0;
    check("f1_writes", 32'(wr_cnt), 11);
    check("f1_start", 32'(start_cnt), 1);
    check("f1_loaded", 32'(loaded), 1);
    check("f1_count", 32'(count), 11);
    check("f1_errs", {30'd0, err_short, err_long}, 0);
    check("f1_ready", 32'(in_ready), 0);
    check("f1_q_empty", 32'(exp_q.size()), 0);

    // short frame: in_last on byte 20 (a Y byte)
    run_frame(20, 0, 0);
    check("short_writes", 32'(wr_cnt), 6);
    check("short_err", 32'(err_short), 1);
    check("short_start", 32'(start_cnt), 0);
    check("short_loaded", 32'(loaded), 0);
    check("short_ready", 32'(in_ready), 0);
    check("short_count", 32'(count), 6);
    check("short_q_empty", 32'(exp_q.size()), 0);

    // long frame: 36 bytes, last three drained
    run_frame(36, 0, 0);
    check("long_writes", 32'(wr_cnt), 11);
    check("long_err_long", 32'(err_long), 1);
    check("long_err_short", 32'(err_short), 0);
    check("long_start", 32'(start_cnt), 1);
    check("long_loaded", 32'(loaded), 1);
    check("long_count", 32'(count), 11);
    check("long_q_empty", 32'(exp_q.size()), 0);

    // reset after byte 10, then a fresh clean frame
    clear_sb();
    pulse_load();
    for (int p = 0; p < 3; p++) exp_q.push_back({5'(p), b[3*p], b[3*p+1], b[3*p+2], 2'b00});
    for (int k = 0; k < 10; k++) send_byte(b[k], 0, 0);
    idle_bus();
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("midrst");
    check("midrst_writes", 32'(wr_cnt), 3);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("postrst_ready", 32'(in_ready), 0);
    run_frame(33, 0, 0);
    check("rerun_writes", 32'(wr_cnt), 11);
    check("rerun_start", 32'(start_cnt), 1);
    check("rerun_loaded", 32'(loaded), 1);
    check("rerun_q_empty", 32'(exp_q.size()), 0);

    // random valid gaps plus a load_start pulse mid-frame
    run_frame(33, 1, 1);
    check("rand_writes", 32'(wr_cnt), 11);
    check("rand_start", 32'(start_cnt), 1);
    check("rand_loaded", 32'(loaded), 1);
    check("rand_errs", {30'd0, err_short, err_long}, 0);
    check("rand_q_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
